// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_resp
// Desc     : In-order responder for the data-SRAM bus with a byte-writable word
//            RAM and two outstanding requests. Define DSRAM_RAND_DELAY_EN to add
//            LFSR-driven 0..3 extra cycles of latency per request.
// Revision : 1.0 - initial release
// ============================================================================
module data_sram_resp #(
   parameter int ADDR_WD = 14,
   parameter int DELAY   = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);

   localparam int         c_depth    = 2 ** ADDR_WD;
   localparam logic [3:0] c_cnt_init = 4'(DELAY - 1);

   logic [31:0]        r_mem [c_depth];
   logic [1:0]         r_vld;
   logic [1:0]         r_ld;
   logic [31:0]        r_dat [2];
   logic [3:0]         r_cnt [2];
   logic               r_rptr;
   logic               r_wptr;
   logic [1:0]         r_occ;

   logic               w_push;
   logic               w_pop;
   logic [ADDR_WD-1:0] w_idx;
   logic [3:0]         w_cnt_load;
   logic               w_unused_bits;

   assign w_idx         = data_sram_addr[ADDR_WD+1:2];
   assign w_unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_WD+2], data_sram_addr[1:0]};

   // Both handshake outputs depend only on registered state, never on req.
   assign data_sram_data_ok = r_vld[r_rptr] && (r_cnt[r_rptr] == 4'd0);
   assign data_sram_addr_ok = (r_occ != 2'd2) || data_sram_data_ok;
   assign data_sram_rdata   = (data_sram_data_ok && r_ld[r_rptr]) ? r_dat[r_rptr] : 32'd0;

   assign w_push = data_sram_req && data_sram_addr_ok;
   assign w_pop  = data_sram_data_ok;

`ifdef DSRAM_RAND_DELAY_EN
   logic [3:0] r_lfsr;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_lfsr <= 4'b1001;
      end else if (w_push) begin
         r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
      end
   end

   assign w_cnt_load = c_cnt_init + {2'b00, r_lfsr[1:0]};
`else
   assign w_cnt_load = c_cnt_init;
`endif

   // RAM survives reset; stores commit at the accepting edge.
   always_ff @(posedge clk) begin
      if (w_push && data_sram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wstrb[i]) begin
               r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_vld  <= 2'b00;
         r_ld   <= 2'b00;
         r_rptr <= 1'b0;
         r_wptr <= 1'b0;
         r_occ  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_dat[i] <= 32'd0;
            r_cnt[i] <= 4'd0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            // A push into the slot being popped (full queue) takes priority.
            if (w_push && (r_wptr == i[0])) begin
               r_vld[i] <= 1'b1;
               r_ld[i]  <= !data_sram_wr;
               r_dat[i] <= r_mem[w_idx];
               r_cnt[i] <= w_cnt_load;
            end else if (w_pop && (r_rptr == i[0])) begin
               r_vld[i] <= 1'b0;
            end else if (r_vld[i] && (r_cnt[i] != 4'd0)) begin
               r_cnt[i] <= r_cnt[i] - 4'd1;
            end
         end
         if (w_push) begin
            r_wptr <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_sram_resp
// Desc     : Randomized bench for data_sram_resp; three instances (DELAY 1, 2, 4)
//            share stimulus and are checked against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_sram_resp;

   localparam int NI = 3;

   logic                 clk = 1'b0;
   logic                 resetn;
   logic                 req;
   logic                 wr;
   logic [1:0]           size;
   logic [3:0]           wstrb;
   logic [31:0]          addr;
   logic [31:0]          wdata;
   logic [NI-1:0]        addr_ok;
   logic [NI-1:0]        data_ok;
   logic [NI-1:0][31:0]  rdata;

   int total = 0;
   int bad   = 0;
   int edge_n = 0;

   // Model: per instance, an ordered list of pending responses with the edge
   // number at which each becomes releasable, plus a shadow of 8 RAM words.
   int          m_cnt [NI];
   int          m_due [NI][2];
   bit          m_ld  [NI][2];
   logic [31:0] m_dat [NI][2];
   logic [31:0] m_mem [NI][8];
   logic [3:0]  m_lfsr [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      data_sram_resp #(
         .ADDR_WD (14),
         .DELAY   ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
      ) u_dut (
         .clk               (clk),
         .resetn            (resetn),
         .data_sram_req     (req),
         .data_sram_wr      (wr),
         .data_sram_size    (size),
         .data_sram_wstrb   (wstrb),
         .data_sram_addr    (addr),
         .data_sram_wdata   (wdata),
         .data_sram_addr_ok (addr_ok[g]),
         .data_sram_data_ok (data_ok[g]),
         .data_sram_rdata   (rdata[g])
      );
   end

   function automatic int dly(int k);
      return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
   endfunction

   function automatic bit exp_dok(int k);
      return (m_cnt[k] > 0) && (m_due[k][0] <= edge_n);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_cnt[k]  = 0;
         m_lfsr[k] = 4'b1001;
      end
   endtask

   task automatic check_outputs();
      for (int k = 0; k < NI; k++) begin
         bit          d;
         logic [31:0] r;
         d = exp_dok(k);
         r = (d && m_ld[k][0]) ? m_dat[k][0] : 32'd0;
         chk($sformatf("addr_ok%0d", k), {31'd0, addr_ok[k]}, {31'd0, (m_cnt[k] < 2) || d});
         chk($sformatf("data_ok%0d", k), {31'd0, data_ok[k]}, {31'd0, d});
         chk($sformatf("rdata%0d", k), rdata[k], r);
      end
   endtask

   // One bus cycle: check outputs, drive a request, advance the model one edge.
   task automatic drive_cycle(input bit rq, input bit w, input logic [3:0] st,
                              input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      check_outputs();
      req   = rq;
      wr    = w;
      wstrb = st;
      addr  = a;
      wdata = d;
      size  = 2'($urandom_range(0, 3));
      for (int k = 0; k < NI; k++) begin
         bit          pop;
         bit          acc;
         int          idx;
         int          extra;
         logic [31:0] rd;
         pop   = exp_dok(k);
         acc   = rq && ((m_cnt[k] < 2) || pop);
         idx   = int'(a[4:2]);
         rd    = m_mem[k][idx];
         extra = 0;
`ifdef DSRAM_RAND_DELAY_EN
         if (acc) begin
            extra     = int'(m_lfsr[k][1:0]);
            m_lfsr[k] = {m_lfsr[k][2:0], m_lfsr[k][3] ^ m_lfsr[k][2]};
         end
`endif
         if (pop) begin
            m_due[k][0] = m_due[k][1];
            m_ld[k][0]  = m_ld[k][1];
            m_dat[k][0] = m_dat[k][1];
            m_cnt[k]--;
         end
         if (acc) begin
            if (w) begin
               for (int b = 0; b < 4; b++) begin
                  if (st[b]) m_mem[k][idx][8*b +: 8] = d[8*b +: 8];
               end
            end
            m_due[k][m_cnt[k]] = edge_n + 1 + dly(k) - 1 + extra;
            m_ld[k][m_cnt[k]]  = !w;
            m_dat[k][m_cnt[k]] = rd;
            m_cnt[k]++;
         end
      end
      @(posedge clk);
      edge_n++;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      check_outputs();
      req = 1'b0;
      #2 resetn = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("rst_addr_ok%0d", k), {31'd0, addr_ok[k]}, 32'd1);
         chk($sformatf("rst_data_ok%0d", k), {31'd0, data_ok[k]}, 32'd0);
         chk($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
      end
      @(posedge clk);
      edge_n++;
      #3 resetn = 1'b1;
   endtask

   function automatic logic [31:0] rand_addr(input int word);
      logic [31:0] h;
      h = $urandom;
      return {h[31:16], 11'd0, 3'(word), h[1:0]};
   endfunction

   initial begin
      logic [31:0] a;
      resetn = 1'b0;
      req    = 1'b0;
      wr     = 1'b0;
      size   = 2'd0;
      wstrb  = 4'd0;
      addr   = 32'd0;
      wdata  = 32'd0;
      model_reset();
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < 8; i++) m_mem[k][i] = 'x;
      end
      #1;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("init_addr_ok%0d", k), {31'd0, addr_ok[k]}, 32'd1);
         chk($sformatf("init_data_ok%0d", k), {31'd0, data_ok[k]}, 32'd0);
      end
      repeat (2) @(posedge clk);
      #3 resetn = 1'b1;

      // Give every shadowed word a known value, spaced so each store is taken.
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1, 1'b1, 4'hF, rand_addr(i), $urandom);
         repeat (10) drive_cycle(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
      end

      // Word store then load, then a single-lane store then load.
      drive_cycle(1'b1, 1'b1, 4'hF,    32'h0000_0010, 32'hDEAD_BEEF);
      drive_cycle(1'b1, 1'b0, 4'h0,    32'h0000_0010, 32'd0);
      drive_cycle(1'b1, 1'b1, 4'b0100, 32'h0000_0010, 32'h00AA_0000);
      drive_cycle(1'b1, 1'b0, 4'h0,    32'h0000_0010, 32'd0);
      repeat (10) drive_cycle(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);

      // Back-to-back loads over all words, then a mixed random run.
      for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, 4'h0, rand_addr(i), 32'd0);
      for (int n = 0; n < 1600; n++) begin
         bit rq;
         if (n == 700) pulse_reset();
         rq = ((n / 200) % 2 == 0) ? 1'b1 : ($urandom_range(0, 9) < 4);
         a  = rand_addr(int'($urandom_range(0, 7)));
         drive_cycle(rq, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
      end
      repeat (12) drive_cycle(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
